// File: rtl/rom_boot_loader.sv
// Boot sequencer: checks the "ASRM" magic at the start of the boot ROM, copies the ROM into RAM,
// and holds the CPU in reset until the copy has finished.
module rom_boot_loader #(
    parameter int unsigned           ROM_ADDR_W = 7,
    parameter int unsigned           ROM_SIZE   = 128,
    parameter int unsigned           RAM_ADDR_W = 16,
    parameter logic [RAM_ADDR_W-1:0] RAM_BASE   = '0,
    parameter logic [31:0]           MAGIC      = 32'h4153524D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_req,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_enable_out,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_write_en,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned     CNT_W    = ROM_ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_SIZE);
    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] CHK_B3   = CNT_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COPY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       chk_idx;
    logic [7:0]       magic_byte;

    // Magic byte compared in CHECK cycle cnt is the one addressed in the previous cycle.
    always_comb begin
        chk_idx    = 2'(cnt - CNT_W'(1));
        magic_byte = MAGIC[31:24];
        case (chk_idx)
            2'd0: magic_byte = MAGIC[31:24];
            2'd1: magic_byte = MAGIC[23:16];
            2'd2: magic_byte = MAGIC[15:8];
            2'd3: magic_byte = MAGIC[7:0];
        endcase
    end

    // The ROM address runs one cycle ahead of the RAM write so the registered write port
    // carries ROM byte i in COPY cycle i+1; the last CHECK cycle already fetches byte 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rom_addr       <= '0;
            rom_enable_out <= 1'b0;
            ram_addr       <= '0;
            ram_data       <= '0;
            ram_write_en   <= 1'b0;
            cpu_reset      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            ram_write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    state          <= S_CHECK;
                    cnt            <= '0;
                    rom_addr       <= '0;
                    rom_enable_out <= 1'b1;
                end
                S_CHECK: begin
                    if ((cnt != '0) && (rom_data != magic_byte)) begin
                        state          <= S_ERROR;
                        rom_enable_out <= 1'b0;
                        error          <= 1'b1;
                    end else if (cnt == CHK_LAST) begin
                        state    <= S_COPY;
                        cnt      <= '0;
                        rom_addr <= rom_addr + ROM_ADDR_W'(1);
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        rom_addr <= (cnt == CHK_B3) ? '0 : ROM_ADDR_W'(cnt + CNT_W'(1));
                    end
                end
                S_COPY: begin
                    if (cnt == CNT_LAST) begin
                        state          <= S_DONE;
                        rom_enable_out <= 1'b0;
                        cpu_reset      <= 1'b1;
                        done           <= 1'b1;
                    end else begin
                        ram_write_en <= 1'b1;
                        ram_addr     <= RAM_BASE + RAM_ADDR_W'(cnt);
                        ram_data     <= rom_data;
                        cnt          <= cnt + CNT_W'(1);
                        rom_addr     <= rom_addr + ROM_ADDR_W'(1);
                    end
                end
                S_DONE, S_ERROR: begin
                    if (boot_req) begin
                        state     <= S_IDLE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: two instances (RAM_BASE 0 and 16'hFFF0) share one ROM model;
// expected RAM writes are queued per boot and popped by a strobe monitor.
module tb_rom_boot_loader;

    localparam int unsigned ROM_SIZE  = 128;
    localparam int          DONE_EDGE = ROM_SIZE + 7;
    localparam logic [15:0] BASE_B    = 16'hFFF0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_req;
    logic [6:0]  rom_addr_a, rom_addr_b;
    logic        rom_en_a, rom_en_b;
    logic [7:0]  rom_data_a, rom_data_b;
    logic [15:0] ram_addr_a, ram_addr_b;
    logic [7:0]  ram_data_a, ram_data_b;
    logic        ram_we_a, ram_we_b;
    logic        cpu_rst_a, cpu_rst_b;
    logic        done_a, done_b;
    logic        error_a, error_b;

    logic [7:0]  rom [ROM_SIZE];
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    wr_t         e_a, e_b;
    string       magic_str = "ASRM";
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;

    always #5 clk = ~clk;

    // Synchronous-read ROM, output forced low when not enabled
    always @(posedge clk) begin
        rom_data_a <= rom_en_a ? rom[rom_addr_a] : 8'h00;
        rom_data_b <= rom_en_b ? rom[rom_addr_b] : 8'h00;
    end

    rom_boot_loader dut_a (
        .clk(clk), .reset(reset), .boot_req(boot_req),
        .rom_addr(rom_addr_a), .rom_enable_out(rom_en_a), .rom_data(rom_data_a),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_write_en(ram_we_a),
        .cpu_reset(cpu_rst_a), .done(done_a), .error(error_a)
    );

    rom_boot_loader #(.RAM_BASE(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .boot_req(boot_req),
        .rom_addr(rom_addr_b), .rom_enable_out(rom_en_b), .rom_data(rom_data_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_write_en(ram_we_b),
        .cpu_reset(cpu_rst_b), .done(done_b), .error(error_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (ram_we_a) begin
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_a: unexpected strobe at ram_addr %0h", ram_addr_a);
            end else begin
                e_a = exp_a.pop_front();
                check("ram_addr_a", 64'(ram_addr_a), 64'(e_a.addr));
                check("ram_data_a", 64'(ram_data_a), 64'(e_a.data));
            end
            wr_cnt_a++;
        end
        if (ram_we_b) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_b: unexpected strobe at ram_addr %0h", ram_addr_b);
            end else begin
                e_b = exp_b.pop_front();
                check("ram_addr_b", 64'(ram_addr_b), 64'(e_b.addr));
                check("ram_data_b", 64'(ram_data_b), 64'(e_b.data));
            end
            if (wr_cnt_b == 16)  check("wrap_addr_b", 64'(ram_addr_b), 64'h0000);
            if (wr_cnt_b == 127) check("last_addr_b", 64'(ram_addr_b), 64'h006F);
            wr_cnt_b++;
        end
    end

    task automatic load_rom(input int bad);
        for (int i = 0; i < int'(ROM_SIZE); i++) rom[i] = 8'($urandom);
        for (int k = 0; k < 4; k++) rom[k] = magic_str[k];
        if (bad >= 0) rom[bad] = rom[bad] ^ 8'($urandom_range(1, 255));
    endtask

    // Reference model: first bad magic byte k ends CHECK on edge k+3, else all bytes are copied
    task automatic push_expect(output int err_edge);
        exp_a.delete();
        exp_b.delete();
        wr_cnt_a = 0;
        wr_cnt_b = 0;
        err_edge = 0;
        for (int k = 0; k < 4; k++)
            if (err_edge == 0 && rom[k] != magic_str[k]) err_edge = k + 3;
        if (err_edge == 0)
            for (int i = 0; i < int'(ROM_SIZE); i++) begin
                exp_a.push_back('{addr: 16'(i), data: rom[i]});
                exp_b.push_back('{addr: 16'((int'(BASE_B) + i) % 65536), data: rom[i]});
            end
    endtask

    task automatic check_reset_vals(input string name);
        check($sformatf("%s_rstval_a", name), 64'({rom_addr_a, rom_en_a, ram_addr_a, ram_data_a,
              ram_we_a, cpu_rst_a, done_a, error_a}), 64'd0);
        check($sformatf("%s_rstval_b", name), 64'({rom_addr_b, rom_en_b, ram_addr_b, ram_data_b,
              ram_we_b, cpu_rst_b, done_b, error_b}), 64'd0);
    endtask

    // Caller guarantees the next rising edge is edge 1 of the boot sequence
    task automatic run_boot(input string name, input int err_edge, input int req_edge);
        int last;
        last = (err_edge != 0) ? err_edge + 3 : DONE_EDGE;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            #1;
            boot_req = (e == req_edge);
            if (err_edge == 0) begin
                if (e == DONE_EDGE - 1) begin
                    check($sformatf("%s_early_a", name), 64'({done_a, cpu_rst_a, error_a}), 64'd0);
                    check($sformatf("%s_early_b", name), 64'({done_b, cpu_rst_b, error_b}), 64'd0);
                end
                if (e == DONE_EDGE) begin
                    check($sformatf("%s_done_a", name),
                          64'({done_a, cpu_rst_a, error_a, ram_we_a, rom_en_a}), 64'(5'b11000));
                    check($sformatf("%s_done_b", name),
                          64'({done_b, cpu_rst_b, error_b, ram_we_b, rom_en_b}), 64'(5'b11000));
                    check($sformatf("%s_nwr_a", name), 64'(wr_cnt_a), 64'(ROM_SIZE));
                    check($sformatf("%s_nwr_b", name), 64'(wr_cnt_b), 64'(ROM_SIZE));
                end
            end else begin
                if (e == err_edge - 1)
                    check($sformatf("%s_err_early", name), 64'({error_a, error_b}), 64'd0);
                if (e == err_edge || e == last) begin
                    check($sformatf("%s_err_a", name),
                          64'({done_a, cpu_rst_a, error_a, rom_en_a}), 64'(4'b0010));
                    check($sformatf("%s_err_b", name),
                          64'({done_b, cpu_rst_b, error_b, rom_en_b}), 64'(4'b0010));
                end
                if (e == last)
                    check($sformatf("%s_nwr", name), 64'(wr_cnt_a + wr_cnt_b), 64'd0);
            end
        end
        boot_req = 1'b0;
    endtask

    task automatic reset_boot(input string name, input int req_edge);
        int ee;
        reset    = 1'b0;
        boot_req = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals(name);
        push_expect(ee);
        @(posedge clk);
        #3;
        reset = 1'b1;
        run_boot(name, ee, req_edge);
    endtask

    // Called #1 after an edge with the DUTs in DONE or ERROR
    task automatic reboot(input string name, input int req_edge);
        int ee;
        push_expect(ee);
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        check($sformatf("%s_req_clr_a", name), 64'({done_a, cpu_rst_a, error_a}), 64'd0);
        check($sformatf("%s_req_clr_b", name), 64'({done_b, cpu_rst_b, error_b}), 64'd0);
        run_boot(name, ee, req_edge);
    endtask

    task automatic abort_boot();
        int ee;
        bit hit;
        hit   = 1'b0;
        reset = 1'b0;
        push_expect(ee);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int e = 1; e <= DONE_EDGE; e++) begin
            @(posedge clk);
            #1;
            if (wr_cnt_a >= 60) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL abort_reach: got %0d writes, expected 60 before timeout", wr_cnt_a);
        end else begin
            check("abort_at_60", 64'(wr_cnt_a), 64'd60);
            #2;
            reset = 1'b0;
            #1;
            check_reset_vals("abort_async");
        end
        reset_boot("after_abort", 0);
    endtask

    initial begin
        int bad;
        reset    = 1'b0;
        boot_req = 1'b0;

        load_rom(-1);
        reset_boot("valid", 0);

        load_rom(-1);
        rom[2] = 8'h00;
        reboot("bad_byte2", 0);

        load_rom(-1);
        reboot("fixed", 0);

        reboot("req_in_copy", 70);

        load_rom(-1);
        abort_boot();

        for (int n = 0; n < 8; n++) begin
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            load_rom(bad);
            if ($urandom_range(0, 3) == 0)
                reset_boot($sformatf("rand%0d", n), 0);
            else
                reboot($sformatf("rand%0d", n), (bad < 0) ? int'($urandom_range(7, 130)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
